// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving a 4:1 WIDTH-bit mux toward a valid/ready consumer.
// A grant holds for up to MAX_BURST accepted beats, then priority rotates past the winner.
module rr_mux_arbiter #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic             o_ready,
  output logic [WIDTH-1:0] o,
  output logic             o_valid,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic [3:0]       ack,
  output logic             busy
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_gnt, w_gnt_nxt;
  logic [1:0]       r_sel, w_sel_nxt;
  logic [1:0]       r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic       w_busy;
  logic       w_req_sel;
  logic       w_accept;
  logic [1:0] w_win;
  logic [1:0] w_idx;
  logic       w_found;

  assign gnt       = r_gnt;
  assign sel       = r_sel;
  assign w_busy    = (r_state == ST_GRANT);
  assign busy      = w_busy;
  assign w_req_sel = req[r_sel];
  // Gated by rst_n so a beat in flight during reset is never acknowledged.
  assign o_valid   = w_busy & w_req_sel & rst_n;
  assign w_accept  = o_valid & o_ready;
  assign ack       = w_accept ? (4'b0001 << r_sel) : 4'b0000;

  // Data path: zeros when idle so no ungranted input leaks out.
  always_comb begin
    o = '0;
    if (w_busy) begin
      case (r_sel)
        2'd0:    o = d0;
        2'd1:    o = d1;
        2'd2:    o = d2;
        default: o = d3;
      endcase
    end
  end

  // First requester found searching upward from the rotating pointer.
  always_comb begin
    w_win   = r_ptr;
    w_idx   = r_ptr;
    w_found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_found && req[w_idx]) begin
        w_win   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_state_nxt = ST_GRANT;
          w_gnt_nxt   = 4'b0001 << w_win;
          w_sel_nxt   = w_win;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        // A dropped request releases at once; otherwise release after the last beat.
        if (!w_req_sel || (w_accept && (r_cnt == LAST_BEAT))) begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = 4'b0000;
          w_cnt_nxt   = '0;
          w_ptr_nxt   = r_sel + 2'd1;
        end else if (w_accept) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= 4'b0000;
      r_sel   <= 2'b00;
      r_ptr   <= 2'b00;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared 4-input, WIDTH-bit output path.
- Four requesters present a request and a data word. The arbiter grants one of them and drives the 2-bit select of the 4:1 data path.
- The granted word is forwarded to a single consumer over a valid/ready handshake.
- A grant is held for a burst of up to MAX_BURST accepted beats. Priority then rotates.

Parameters:
- WIDTH, 4, data width of each input word and of the output word.
- MAX_BURST, 4, maximum accepted beats per grant; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- req  input  4  request; bit i is asserted by requester i while it has data on di.
- d0  input  WIDTH  requester 0 data.
- d1  input  WIDTH  requester 1 data.
- d2  input  WIDTH  requester 2 data.
- d3  input  WIDTH  requester 3 data.
- o_ready  input  1  consumer can accept a beat this cycle.
- o  output  WIDTH  selected data word.
- o_valid  output  1  o holds a valid beat.
- gnt  output  4  one-hot grant, registered.
- sel  output  2  registered select (00 selects d0, 01 selects d1, 10 selects d2, 11 selects d3).
- ack  output  4  one-cycle pulse on bit sel when a beat is accepted.
- busy  output  1  high while in GRANT.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State returns to IDLE.
  - gnt=0000, sel=00.
  - Rotating pointer ptr=00; beat counter cnt=0.
  - Consequently o_valid=0, ack=0000, busy=0, o=0.
  - Reset mid-burst aborts the burst; the in-flight beat is not acked.
- States: IDLE, GRANT.
- IDLE:
  - If req != 0, pick the first set bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Load gnt/sel with the winner, cnt=0, go to GRANT.
  - If req == 0, remain in IDLE.
  - Latency: req sampled at edge N produces gnt/sel valid after edge N; the first beat can be offered in cycle N+1.
- GRANT (combinational outputs):
  - o_valid = req[sel].
  - o = d[sel].
  - ack[sel] = o_valid & o_ready; all other ack bits are 0.
  - busy = 1.
- GRANT (edge rules):
  - Accepted beat (o_valid & o_ready) with cnt == MAX_BURST-1: release.
  - Accepted beat with cnt < MAX_BURST-1: cnt = cnt+1, stay in GRANT.
  - req[sel]=0: release immediately (zero-beat grant allowed); no ack.
  - o_valid=1, o_ready=0: hold everything. o/sel remain stable; the requester must keep d stable.
  - Release: ptr = sel+1 (mod 4), gnt=0000, cnt=0, go to IDLE. This costs one dead arbitration cycle between grants.
- Outputs in IDLE: o is forced to all zeros; the output is never high-impedance and never leaks an ungranted input.
- Requests from other requesters during GRANT are ignored until release; no preemption.
- Wrap-around: ptr increments from 11 to 00.
- Starvation bound: any continuously asserted req is granted within 3 other grants.
- cnt width is 4 bits. MAX_BURST=1 gives single-beat grants.
- gnt is always one-hot or zero. sel matches gnt whenever gnt != 0 and holds its last value in IDLE.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with req=1111, d0..d3=0001/0010/0100/1000 -> gnt=0000, o_valid=0, o=0000, busy=0; after release, the first grant is gnt=0001, sel=00.
2. Single requester: req=0100, o_ready=1, MAX_BURST=4 -> gnt=0100, o=0100, four ack[2] pulses on consecutive cycles, then IDLE for one cycle, then re-grant to requester 2.
3. Round robin: req=1111 held, o_ready=1, MAX_BURST=2 -> grant order 0,1,2,3,0 with two beats each; o sequence 0001,0001,0010,0010,0100,0100,1000,1000.
4. Backpressure: granted requester 1 with o_ready=0 for 5 cycles -> o=0010, o_valid=1, no ack, cnt unchanged; on o_ready=1 one ack[1] pulse follows.
5. Early release: requester 3 granted, req[3] drops after 1 accepted beat -> release; next grant searches from ptr=00.
6. Reset mid-burst: rst_n=0 during the 2nd beat of a 4-beat burst -> no ack that cycle; gnt=0000 next cycle; ptr=00 after reset.
